// File: rtl/mips_pkg.sv
// Shared encodings for the execute stage: ALU operation codes and the
// execute-unit state machine states.
package mips_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SLT  = 4'h5,
        OP_SLTU = 4'h6,
        OP_SLL  = 4'h7,
        OP_SRL  = 4'h8,
        OP_SRA  = 4'h9,
        OP_MUL  = 4'hA
    } alu_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_MUL;
    endfunction

endpackage

// File: rtl/execute_unit_mul_seq.sv
// Shift-add multiplier: one partial product per clock, WIDTH iterations,
// low WIDTH bits of the unsigned product. done/product are valid on the last iteration.
module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] addend;
    logic [CW-1:0]    count_reg;
    logic             busy_reg;

    // Partial product: the shifted multiplicand gated by the current multiplier bit.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
        assign addend[gi] = a_reg[gi] & b_reg[0];
    end

    assign acc_next = acc_reg + addend;
    assign done     = busy_reg && (count_reg == '0);
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b0;
        end else if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            acc_reg   <= '0;
            count_reg <= CW'(WIDTH - 1);
            busy_reg  <= 1'b1;
        end else if (busy_reg) begin
            acc_reg   <= acc_next;
            a_reg     <= a_reg << 1;
            b_reg     <= b_reg >> 1;
            count_reg <= count_reg - 1'b1;
            if (count_reg == '0) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU operations plus a 32-iteration sequential
// multiply; results are pulsed to the register-file write port.
module execute_unit
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [3:0]                aluOp,
    input  logic [DATA_WIDTH-1:0]     operandA,
    input  logic [DATA_WIDTH-1:0]     operandB,
    input  logic [REG_ADDR_WIDTH-1:0] destRegister,
    input  logic                      writeBack,
    output logic [DATA_WIDTH-1:0]     result,
    output logic [REG_ADDR_WIDTH-1:0] resultRegister,
    output logic                      enableSavingResult,
    output logic                      resultValid,
    output logic                      illegalOp
);

    state_t                    state_reg;
    state_t                    state_next;
    alu_op_t                   op;
    logic                      accept;
    logic                      is_mul;
    logic                      mul_done;
    logic [4:0]                shamt;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     mul_product;
    logic [DATA_WIDTH-1:0]     result_reg;
    logic [REG_ADDR_WIDTH-1:0] result_register_reg;
    logic [REG_ADDR_WIDTH-1:0] pend_dest_reg;
    logic                      pend_wb_reg;
    logic                      wb_out_reg;
    logic                      result_valid_reg;
    logic                      illegal_reg;

    assign op     = alu_op_t'(aluOp);
    assign accept = inValid && inReady;
    assign is_mul = (op == OP_MUL);
    assign shamt  = operandB[4:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept && is_mul) state_next = ST_MUL;
            ST_MUL:  if (mul_done)         state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        inReady = (state_reg == ST_IDLE);
    end

    always_comb begin
        alu_result = '0;
        case (op)
            OP_ADD:  alu_result = operandA + operandB;
            OP_SUB:  alu_result = operandA - operandB;
            OP_AND:  alu_result = operandA & operandB;
            OP_OR:   alu_result = operandA | operandB;
            OP_XOR:  alu_result = operandA ^ operandB;
            OP_SLT:  alu_result[0] = $signed(operandA) < $signed(operandB);
            OP_SLTU: alu_result[0] = operandA < operandB;
            OP_SLL:  alu_result = operandA << shamt;
            OP_SRL:  alu_result = operandA >> shamt;
            OP_SRA:  alu_result = $signed(operandA) >>> shamt;
            default: alu_result = '0;
        endcase
    end

    mul_seq #(
        .WIDTH(DATA_WIDTH)
    ) u_mul_seq (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && is_mul),
        .a       (operandA),
        .b       (operandB),
        .done    (mul_done),
        .product (mul_product)
    );

    // Output registers change only on a result pulse, so they hold between pulses;
    // a multiply's destination waits in pend_* until the product is ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_reg          <= '0;
            result_register_reg <= '0;
            pend_dest_reg       <= '0;
            pend_wb_reg         <= 1'b0;
            wb_out_reg          <= 1'b0;
            result_valid_reg    <= 1'b0;
            illegal_reg         <= 1'b0;
        end else begin
            result_valid_reg <= 1'b0;
            illegal_reg      <= 1'b0;
            if (accept && !is_mul) begin
                result_reg          <= alu_result;
                result_register_reg <= destRegister;
                wb_out_reg          <= writeBack;
                illegal_reg         <= !op_is_legal(aluOp);
                result_valid_reg    <= 1'b1;
            end else if (accept) begin
                pend_dest_reg <= destRegister;
                pend_wb_reg   <= writeBack;
            end
            if (state_reg == ST_MUL && mul_done) begin
                result_reg          <= mul_product;
                result_register_reg <= pend_dest_reg;
                wb_out_reg          <= pend_wb_reg;
                result_valid_reg    <= 1'b1;
            end
        end
    end

    assign result             = result_reg;
    assign resultRegister     = result_register_reg;
    assign resultValid        = result_valid_reg;
    assign illegalOp          = illegal_reg;
    assign enableSavingResult = result_valid_reg && wb_out_reg && !illegal_reg;

endmodule
